// File: rtl/alu_pc_unit_pkg.sv
// Shared types for the ALU / program-counter slice.
// Optional branch statistics are enabled with the ALU_PC_BR_STATS_EN macro
// (see alu_pc_unit.sv).
package alu_pc_unit_pkg;

    // ALU operation codes used by the upstream ALU.
    typedef enum logic [1:0] {
        kADD = 2'b00,
        kSUB = 2'b01,
        kAND = 2'b10,
        kXOR = 2'b11
    } alu_op_t;

    // Conditional-branch conditions, evaluated against the latched flags.
    typedef enum logic [1:0] {
        kALWAYS = 2'b00,
        kIFEQ   = 2'b01,
        kIFNE   = 2'b10,
        kIFZ    = 2'b11
    } br_cond_t;

    // Run/halt framing states.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        HALTED = 2'b10
    } pc_state_t;

    // Saturation ceiling of the taken-branch counter.
    localparam logic [15:0] BR_COUNT_MAX = 16'hFFFF;

endpackage

// File: rtl/alu_pc_cond.sv
// Combinational branch-condition evaluator: decides whether a branch with the
// given condition would be taken using the latched Z/E flags.
module alu_pc_cond
    import alu_pc_unit_pkg::*;
(
    input  logic     i_flag_z,
    input  logic     i_flag_e,
    input  br_cond_t i_cond,
    output logic     o_taken
);

    // Decode the condition against the stored flags.
    always_comb begin
        o_taken = 1'b0;
        case (i_cond)
            kALWAYS: o_taken = 1'b1;
            kIFEQ:   o_taken = i_flag_e;
            kIFNE:   o_taken = ~i_flag_e;
            kIFZ:    o_taken = i_flag_z;
        endcase
    end

endmodule

// File: rtl/alu_pc_unit.sv
// Program-counter / branch-resolution stage downstream of the ALU.
// Latches ALU ZERO/EQUAL on compare instructions, resolves conditional
// branches against those latched flags and produces the next PC each cycle,
// framed by an IDLE/RUN/HALTED state machine.
// Optional feature: define ALU_PC_BR_STATS_EN to add the saturating
// taken-branch counter output BR_COUNT.
module alu_pc_unit
    import alu_pc_unit_pkg::*;
#(
    parameter int unsigned     PC_W       = 10,
    parameter int unsigned     OFF_W      = 8,
    parameter logic [PC_W-1:0] START_ADDR = '0
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic             HALT_REQ,
    input  logic             STALL,
    input  logic             FLAG_WR,
    input  logic             ZERO,
    input  logic             EQUAL,
    input  logic             BR_EN,
    input  br_cond_t         BR_COND,
    input  logic             BR_ABS,
    input  logic [PC_W-1:0]  BR_TARGET,
    input  logic [OFF_W-1:0] BR_OFFSET,
    output logic [PC_W-1:0]  PC,
    output logic             RUNNING,
    output logic             DONE,
    output logic             BR_TAKEN
`ifdef ALU_PC_BR_STATS_EN
    ,
    output logic [15:0]      BR_COUNT
`endif
);

    pc_state_t       r_state;
    logic [PC_W-1:0] r_pc;
    logic            r_running;
    logic            r_done;
    logic            r_br_taken;
    logic            r_flag_z;
    logic            r_flag_e;

    logic            w_cond_ok;
    logic            w_taken;
    logic            w_start_ok;
    logic            w_advance;
    logic [PC_W-1:0] w_off_ext;
    logic [PC_W-1:0] w_target;

    alu_pc_cond u_cond (
        .i_flag_z (r_flag_z),
        .i_flag_e (r_flag_e),
        .i_cond   (BR_COND),
        .o_taken  (w_cond_ok)
    );

    // START is only honoured outside RUN; in RUN a HALT_REQ or STALL blocks progress.
    assign w_start_ok = START && ((r_state == IDLE) || (r_state == HALTED));
    assign w_advance  = (r_state == RUN) && !HALT_REQ && !STALL;
    assign w_taken    = BR_EN && w_cond_ok;

    // Relative targets wrap silently modulo 2^PC_W in both directions.
    assign w_off_ext  = PC_W'($signed(BR_OFFSET));
    assign w_target   = BR_ABS ? BR_TARGET : (r_pc + w_off_ext);

    // Run/halt FSM with PC, flags and registered status outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state    <= IDLE;
            r_pc       <= START_ADDR;
            r_running  <= 1'b0;
            r_done     <= 1'b0;
            r_br_taken <= 1'b0;
            r_flag_z   <= 1'b0;
            r_flag_e   <= 1'b0;
        end else begin
            r_br_taken <= 1'b0;
            case (r_state)
                IDLE, HALTED: begin
                    if (w_start_ok) begin
                        r_state   <= RUN;
                        r_pc      <= START_ADDR;
                        r_flag_z  <= 1'b0;
                        r_flag_e  <= 1'b0;
                        r_running <= 1'b1;
                        r_done    <= 1'b0;
                    end
                end
                RUN: begin
                    if (HALT_REQ) begin
                        r_state   <= HALTED;
                        r_running <= 1'b0;
                        r_done    <= 1'b1;
                    end else if (w_advance) begin
                        // Branch sees the old flags; a same-cycle FLAG_WR lands afterwards.
                        r_pc       <= w_taken ? w_target : (r_pc + PC_W'(1));
                        r_br_taken <= w_taken;
                        if (FLAG_WR) begin
                            r_flag_z <= ZERO;
                            r_flag_e <= EQUAL;
                        end
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_running <= 1'b0;
                    r_done    <= 1'b0;
                end
            endcase
        end
    end

    assign PC       = r_pc;
    assign RUNNING  = r_running;
    assign DONE     = r_done;
    assign BR_TAKEN = r_br_taken;

`ifdef ALU_PC_BR_STATS_EN
    logic [15:0] r_br_count;

    // Saturating count of taken branches; restarts with each program run.
    always_ff @(posedge CLK) begin
        if (RESET || w_start_ok) begin
            r_br_count <= '0;
        end else if (w_advance && w_taken && (r_br_count != BR_COUNT_MAX)) begin
            r_br_count <= r_br_count + 16'd1;
        end
    end

    assign BR_COUNT = r_br_count;
`endif

endmodule
